bus_capture_fifo: RTL and testbench

//   Read-side endpoint of the shared 8-bit tri-state data bus. Counters and registers drive
//   the bus when their output enable is high. This block samples the bus on a capture strobe
//   and buffers the words in a small FIFO.
//   A downstream consumer drains the FIFO over a valid/ready handshake. The FIFO decouples
//   bus-transfer timing from consumer timing.

---
 rtl/bus_capture_fifo.sv | 98 +++++++++
 tb/tb_bus_capture_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_capture_fifo.sv
// bus_capture_fifo: samples the shared 8-bit tri-state bus on a capture strobe and
// buffers the words in a small first-word-fall-through FIFO drained by valid/ready.
// Optional feature macro: BUS_CAPTURE_FLUSH_EN adds a synchronous flush input that
// empties the FIFO and clears the sticky overflow flag.
module bus_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           bus_in,
  input  logic                       cap,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef BUS_CAPTURE_FLUSH_EN
  input  logic                       flush,
`endif
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_flush;

  // Status decoded from the stored count only; pointers are never compared.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);

  // A full FIFO still accepts a capture when the head is popped in the same cycle.
  assign w_pop   = w_valid && out_ready;
  assign w_push  = cap && (!w_full || w_pop);
  assign w_drop  = cap && w_full && !w_pop;

`ifdef BUS_CAPTURE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Storage write; contents need no reset because out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= bus_in;
    end
  end

  // Pointer, count and sticky overflow bookkeeping; flush outranks cap and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign out_valid = w_valid;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_bus_capture_fifo.sv
// tb_bus_capture_fifo: randomized and directed stimulus against a queue-based
// reference model; a negedge monitor compares DUT outputs with the model.
module tb_bus_capture_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] bus_in;
  logic             cap;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic [2:0]       count;
  logic             overflow;
`ifdef BUS_CAPTURE_FLUSH_EN
  logic             flush;
`endif

  int checks;
  int failures;

  // Reference model: the FIFO contents as a plain queue plus the sticky flag.
  logic [WIDTH-1:0] mq [$];
  bit               m_ovf;

  bus_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_in    (bus_in),
    .cap       (cap),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BUS_CAPTURE_FLUSH_EN
    .flush     (flush),
`endif
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: compare outputs to the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      int exp_data;
      bit pop;
      exp_data = (mq.size() > 0) ? int'(mq[0]) : 0;
      check("count", int'(count), mq.size());
      check("out_valid", int'(out_valid), int'(mq.size() > 0));
      check("full", int'(full), int'(mq.size() == DEPTH));
      check("overflow", int'(overflow), int'(m_ovf));
      check("out_data", int'(out_data), exp_data);
      if (cap && $isunknown(bus_in)) begin
        failures++;
        $display("FAIL bus_protocol: cap with unknown bus_in at %0t", $time);
      end
`ifdef BUS_CAPTURE_FLUSH_EN
      if (flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
`else
      begin
`endif
        pop = (mq.size() > 0) && out_ready;
        if (pop) void'(mq.pop_front());
        if (cap) begin
          if (mq.size() < DEPTH) mq.push_back(bus_in);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic c, input logic [WIDTH-1:0] d, input logic r);
    @(posedge clk);
    #1;
    cap       = c;
    bus_in    = d;
    out_ready = r;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cap       = 1'b0;
    bus_in    = '0;
    out_ready = 1'b0;
`ifdef BUS_CAPTURE_FLUSH_EN
    flush     = 1'b0;
`endif
    rst_n     = 1'b0;
    #2;
    check("reset_count", int'(count), 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Capture three words, then drain in order.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("cap3_count", int'(count), 3);
    check("cap3_head", int'(out_data), 8'h11);
    drain(4);
    check("drain_valid", int'(out_valid), 0);

    // Overflow: five captures into four slots.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("ovf_full", int'(full), 1);
    check("ovf_count", int'(count), 4);
    check("ovf_flag", int'(overflow), 1);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check("ovf_pop_count", int'(count), 3);

    // Asynchronous reset mid-stream with three words stored and overflow set.
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_ovf", int'(overflow), 0);
    check("arst_data", int'(out_data), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Full with simultaneous capture and pop.
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b1, 8'h55, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check("fullpp_count", int'(count), 4);
    check("fullpp_ovf", int'(overflow), 0);
    check("fullpp_head", int'(out_data), 2);
    drain(5);
    check("fullpp_empty", int'(out_valid), 0);

    // Wrap-around with one word in flight.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      check("wrap_count_le1", int'(count <= 3'd1), 1);
    end
    drain(2);

`ifdef BUS_CAPTURE_FLUSH_EN
    // Flush beats simultaneous cap and pop.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
    drain(2);
    drive(1'b0, 8'h00, 1'b0);
    check("fl_pre_count", int'(count), 2);
    check("fl_pre_ovf", int'(overflow), 1);
    drive(1'b1, 8'h77, 1'b1);
    flush = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    flush = 1'b0;
    check("fl_count", int'(count), 0);
    check("fl_ovf", int'(overflow), 0);
    check("fl_valid", int'(out_valid), 0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
`ifdef BUS_CAPTURE_FLUSH_EN
      flush = 1'($urandom_range(0, 99) < 2);
`endif
    end
`ifdef BUS_CAPTURE_FLUSH_EN
    flush = 1'b0;
`endif
    drain(6);
    check("final_empty", int'(out_valid), 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
